// File: rtl/csr_counter_arbiter_pkg.sv
// Shared definitions for the CSR counter read-port arbiter: counter op encodings
// (common with csrFile), debug counter selects and the debug read FSM states.
package csr_counter_arbiter_pkg;

  // Counter read op encodings, shared with csrFile.csrOp.
  localparam logic [1:0] CSR_CYCLE_LOW    = 2'd0;
  localparam logic [1:0] CSR_CYCLE_HIGH   = 2'd1;
  localparam logic [1:0] CSR_INSTRET_LOW  = 2'd2;
  localparam logic [1:0] CSR_INSTRET_HIGH = 2'd3;

  // Debug counter select values.
  localparam logic DBG_SEL_INSTRET = 1'b0;
  localparam logic DBG_SEL_CYCLE   = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRdHi1,
    StRdLo,
    StRdHi2,
    StResp
  } dbg_rd_state_e;

  // Op for the high or low half of the debug-selected counter.
  function automatic logic [1:0] dbg_op(input logic sel, input logic high);
    if (sel == DBG_SEL_CYCLE) begin
      return high ? CSR_CYCLE_HIGH : CSR_CYCLE_LOW;
    end
    return high ? CSR_INSTRET_HIGH : CSR_INSTRET_LOW;
  endfunction

endpackage

// File: rtl/csr_counter_arbiter.sv
// Arbitrates the single csrFile counter read port between EX-stage CSR reads
// (absolute priority, combinational pass-through) and a debug port that returns a
// coherent 64-bit counter value using a high/low/high read with bounded retry.
module csr_counter_arbiter
  import csr_counter_arbiter_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  // EX-stage CSR path
  input  logic        cpu_csr_req,
  input  logic [1:0]  cpu_csr_op,
  output logic [31:0] cpu_csr_rdata,
  // Debug request/response
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_req_sel,
  output logic        dbg_rsp_valid,
  input  logic        dbg_rsp_ready,
  output logic [63:0] dbg_rsp_data,
  output logic        dbg_rsp_err,
  // csrFile read port
  output logic        csr_enable,
  output logic [1:0]  csr_op,
  input  logic [31:0] csr_rdata
);

  // A zero retry budget still needs a one-bit counter to stay legal.
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  dbg_rd_state_e     state_q;
  logic              sel_q;
  logic [RetryW-1:0] retry_q;
  logic [31:0]       hi1_q;
  logic [31:0]       lo_q;
  logic [63:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              rsp_valid_q;
  logic              dbg_rd;

  // Port mux: CPU always wins; otherwise the debug FSM drives the half it needs.
  always_comb begin
    dbg_rd        = 1'b0;
    csr_op        = 2'd0;
    cpu_csr_rdata = cpu_csr_req ? csr_rdata : 32'd0;
    dbg_req_ready = (state_q == StIdle);
    unique case (state_q)
      StRdHi1, StRdHi2: begin
        dbg_rd = 1'b1;
        csr_op = dbg_op(sel_q, 1'b1);
      end
      StRdLo: begin
        dbg_rd = 1'b1;
        csr_op = dbg_op(sel_q, 1'b0);
      end
      default: ;
    endcase
    if (cpu_csr_req) begin
      csr_op = cpu_csr_op;
    end
    csr_enable = cpu_csr_req | dbg_rd;
  end

  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_data  = rsp_data_q;
  assign dbg_rsp_err   = rsp_err_q;

  // Debug read FSM with data latches; every RD_* state freezes while the CPU owns the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= DBG_SEL_INSTRET;
      retry_q     <= '0;
      hi1_q       <= 32'd0;
      lo_q        <= 32'd0;
      rsp_data_q  <= 64'd0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dbg_req_valid) begin
            sel_q   <= dbg_req_sel;
            retry_q <= '0;
            state_q <= StRdHi1;
          end
        end
        StRdHi1: begin
          if (!cpu_csr_req) begin
            hi1_q   <= csr_rdata;
            state_q <= StRdLo;
          end
        end
        StRdLo: begin
          if (!cpu_csr_req) begin
            lo_q    <= csr_rdata;
            state_q <= StRdHi2;
          end
        end
        StRdHi2: begin
          if (!cpu_csr_req) begin
            if (csr_rdata == hi1_q) begin
              rsp_data_q  <= {hi1_q, lo_q};
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else if (retry_q != RetryMax) begin
              // Torn read: the fresh high word becomes the reference for the re-read.
              retry_q <= retry_q + RetryW'(1);
              hi1_q   <= csr_rdata;
              state_q <= StRdLo;
            end else begin
              rsp_data_q  <= {csr_rdata, lo_q};
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end
          end
        end
        StResp: begin
          if (dbg_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_counter_arbiter.sv
// Self-checking bench for csr_counter_arbiter: a behavioural counter file plus a
// sample-list reference model of the coherent debug read, directed and random stimulus.
module tb_csr_counter_arbiter;
  import csr_counter_arbiter_pkg::*;

  localparam int unsigned MaxRetry = 3;

  logic        clk;
  logic        rst_n;
  logic        cpu_csr_req;
  logic [1:0]  cpu_csr_op;
  logic [31:0] cpu_csr_rdata;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_sel;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [63:0] dbg_rsp_data;
  logic        dbg_rsp_err;
  logic        csr_enable;
  logic [1:0]  csr_op;
  logic [31:0] csr_rdata;

  csr_counter_arbiter #(
    .MAX_RETRY(MaxRetry)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_csr_req  (cpu_csr_req),
    .cpu_csr_op   (cpu_csr_op),
    .cpu_csr_rdata(cpu_csr_rdata),
    .dbg_req_valid(dbg_req_valid),
    .dbg_req_ready(dbg_req_ready),
    .dbg_req_sel  (dbg_req_sel),
    .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_data (dbg_rsp_data),
    .dbg_rsp_err  (dbg_rsp_err),
    .csr_enable   (csr_enable),
    .csr_op       (csr_op),
    .csr_rdata    (csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counter file. In tear mode every counter reads as {tear_hi, tear_lo}
  // and tear_hi steps after each high-word read.
  logic [63:0] cyc64;
  logic [63:0] ins64;
  logic        ins_inc;
  logic        tear_mode;
  logic [31:0] tear_hi;
  logic [31:0] tear_lo;
  logic        last_en;
  logic [1:0]  last_op;
  logic [63:0] port_val;

  function automatic logic op_cycle(input logic [1:0] op);
    return (op == CSR_CYCLE_HIGH) || (op == CSR_CYCLE_LOW);
  endfunction

  function automatic logic op_high(input logic [1:0] op);
    return (op == CSR_CYCLE_HIGH) || (op == CSR_INSTRET_HIGH);
  endfunction

  assign port_val  = tear_mode ? {tear_hi, tear_lo} : (op_cycle(csr_op) ? cyc64 : ins64);
  assign csr_rdata = op_high(csr_op) ? port_val[63:32] : port_val[31:0];

  function automatic logic [63:0] cnt_val(input logic sel);
    if (tear_mode) return {tear_hi, tear_lo};
    return (sel == DBG_SEL_CYCLE) ? cyc64 : ins64;
  endfunction

  function automatic logic [31:0] cpu_half(input logic [1:0] op);
    logic [63:0] v;
    v = cnt_val(op_cycle(op) ? DBG_SEL_CYCLE : DBG_SEL_INSTRET);
    return op_high(op) ? v[63:32] : v[31:0];
  endfunction

  // Reference model: samples of the selected counter on each port cycle the debug
  // side actually gets, alternating high, low, high, low, high ...
  int          n_cmp;
  int          n_err;
  int          cyc_n;
  int          acc_cyc;
  int          rsp_lat;
  bit          rsp_seen;
  bit          m_busy;
  bit          m_resp;
  logic        m_sel;
  logic [63:0] m_data;
  logic        m_err;
  logic [63:0] samples[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Decide from the latest high/low/high triple whether the read is finished.
  function automatic bit model_done(output logic [63:0] d, output logic e);
    int unsigned n;
    int unsigned retries;
    logic [31:0] hi_ref;
    logic [31:0] lo;
    logic [31:0] hi_new;
    n = samples.size();
    d = '0;
    e = 1'b0;
    if (n < 3 || (n % 2) == 0) return 1'b0;
    hi_ref  = samples[n-3][63:32];
    lo      = samples[n-2][31:0];
    hi_new  = samples[n-1][63:32];
    retries = (n - 3) / 2;
    if (hi_new == hi_ref) begin
      d = {hi_ref, lo};
      return 1'b1;
    end
    if (retries == MaxRetry) begin
      d = {hi_new, lo};
      e = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic upd_counters();
    cyc64 = cyc64 + 64'd1;
    ins64 = ins64 + {63'd0, ins_inc};
    if (tear_mode && last_en && op_high(last_op)) tear_hi = tear_hi + 32'd1;
  endtask

  // One clock cycle: drive at edge+1, check at edge+4, advance model, step counters.
  task automatic run_cycle(input logic creq, input logic [1:0] cop, input logic dv,
                           input logic dsel, input logic rr);
    logic        een;
    logic [1:0]  eop;
    logic [63:0] d;
    logic        e;
    bit          hi_phase;
    cpu_csr_req   = creq;
    cpu_csr_op    = cop;
    dbg_req_valid = dv;
    dbg_req_sel   = dsel;
    dbg_rsp_ready = rr;
    ins_inc       = 1'($urandom_range(0, 1));
    #3;
    check_eq("req_ready", dbg_req_ready, !m_busy && !m_resp);
    check_eq("rsp_valid", dbg_rsp_valid, m_resp);
    if (m_resp) begin
      check_eq("rsp_data", dbg_rsp_data, m_data);
      check_eq("rsp_err", dbg_rsp_err, m_err);
    end
    check_eq("cpu_rdata", cpu_csr_rdata, creq ? cpu_half(cop) : 32'd0);
    hi_phase = (samples.size() % 2) == 0;
    een = creq || m_busy;
    if (creq) eop = cop;
    else if (m_busy) eop = dbg_op(m_sel, hi_phase);
    else eop = 2'd0;
    check_eq("csr_enable", csr_enable, een);
    check_eq("csr_op", csr_op, eop);
    last_en = csr_enable;
    last_op = csr_op;
    if (dbg_rsp_valid && !rsp_seen) begin
      rsp_seen = 1'b1;
      rsp_lat  = cyc_n - acc_cyc;
    end
    if (m_resp) begin
      if (rr) m_resp = 1'b0;
    end else if (m_busy) begin
      if (!creq) begin
        samples.push_back(cnt_val(m_sel));
        if (model_done(d, e)) begin
          m_busy = 1'b0;
          m_resp = 1'b1;
          m_data = d;
          m_err  = e;
        end
      end
    end else if (dv) begin
      m_busy = 1'b1;
      m_sel  = dsel;
      samples.delete();
      acc_cyc  = cyc_n;
      rsp_seen = 1'b0;
    end
    @(posedge clk);
    #1;
    upd_counters();
    cyc_n++;
  endtask

  task automatic wait_rsp(input int budget);
    int k;
    k = 0;
    while (!rsp_seen && k < budget) begin
      run_cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    if (!rsp_seen) check_eq("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume();
    run_cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_eq("idle_after_rsp", dbg_req_ready, 1'b1);
  endtask

  logic [63:0] snap_data;
  logic        snap_err;

  initial begin
    n_cmp = 0; n_err = 0; cyc_n = 0; acc_cyc = 0; rsp_lat = 0; rsp_seen = 1'b0;
    m_busy = 1'b0; m_resp = 1'b0; m_sel = 1'b0; m_data = '0; m_err = 1'b0;
    cyc64 = 64'd0; ins64 = 64'h0000_0003_FFFF_FF00; ins_inc = 1'b0;
    tear_mode = 1'b0; tear_hi = 32'd0; tear_lo = 32'd0; last_en = 1'b0; last_op = 2'd0;
    rst_n = 1'b0; cpu_csr_req = 1'b0; cpu_csr_op = 2'd0; dbg_req_valid = 1'b1;
    dbg_req_sel = 1'b0; dbg_rsp_ready = 1'b0;

    // Reset state, with a request already pending that must be ignored.
    #12;
    check_eq("rst_rsp_valid", dbg_rsp_valid, 1'b0);
    check_eq("rst_rsp_data", dbg_rsp_data, 64'd0);
    check_eq("rst_rsp_err", dbg_rsp_err, 1'b0);
    check_eq("rst_csr_enable", csr_enable, 1'b0);
    dbg_req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    upd_counters();

    // Uncontended cycle read: low word 0x10 at the RD_LO cycle.
    cyc64 = 64'h0000_0005_0000_000E;
    run_cycle(1'b0, 2'd0, 1'b1, DBG_SEL_CYCLE, 1'b0);
    wait_rsp(20);
    check_eq("idle_lat", 64'(rsp_lat), 64'd4);
    check_eq("idle_data", dbg_rsp_data, 64'h0000_0005_0000_0010);
    check_eq("idle_err", dbg_rsp_err, 1'b0);
    consume();

    // CPU owns the port for three cycles right after accept.
    run_cycle(1'b0, 2'd0, 1'b1, DBG_SEL_INSTRET, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    wait_rsp(20);
    check_eq("cont_lat", 64'(rsp_lat), 64'd7);
    consume();

    // Low word reads 0xFFFF_FFFF: one retry, high word taken from the second read.
    cyc64 = 64'h0000_0001_FFFF_FFFD;
    run_cycle(1'b0, 2'd0, 1'b1, DBG_SEL_CYCLE, 1'b0);
    wait_rsp(20);
    check_eq("carry_lat", 64'(rsp_lat), 64'd6);
    check_eq("carry_data", dbg_rsp_data, 64'h0000_0002_0000_0001);
    check_eq("carry_err", dbg_rsp_err, 1'b0);
    consume();

    // Every high read tears: budget exhausted after three retries.
    tear_mode = 1'b1; tear_hi = 32'd7; tear_lo = 32'h0000_ABCD;
    run_cycle(1'b0, 2'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    wait_rsp(30);
    check_eq("tear_lat", 64'(rsp_lat), 64'd10);
    check_eq("tear_data", dbg_rsp_data, 64'h0000_000B_0000_ABCD);
    check_eq("tear_err", dbg_rsp_err, 1'b1);
    consume();
    tear_mode = 1'b0;

    // Response backpressure for five cycles.
    run_cycle(1'b0, 2'd0, 1'b1, DBG_SEL_CYCLE, 1'b0);
    wait_rsp(20);
    snap_data = dbg_rsp_data;
    snap_err  = dbg_rsp_err;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
      check_eq("bp_data", dbg_rsp_data, snap_data);
      check_eq("bp_err", dbg_rsp_err, snap_err);
      check_eq("bp_req_ready", dbg_req_ready, 1'b0);
    end
    consume();

    // Reset while in RD_LO: everything drops, then a fresh read completes.
    run_cycle(1'b0, 2'd0, 1'b1, DBG_SEL_CYCLE, 1'b0);
    run_cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cpu_csr_req = 1'b0; dbg_req_valid = 1'b0; dbg_rsp_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_valid", dbg_rsp_valid, 1'b0);
    check_eq("mid_rst_data", dbg_rsp_data, 64'd0);
    check_eq("mid_rst_err", dbg_rsp_err, 1'b0);
    check_eq("mid_rst_enable", csr_enable, 1'b0);
    check_eq("mid_rst_ready", dbg_req_ready, 1'b1);
    @(posedge clk);
    #1;
    upd_counters();
    cyc_n++;
    rst_n = 1'b1;
    m_busy = 1'b0; m_resp = 1'b0; samples.delete();
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 2'd0, 1'b1, DBG_SEL_INSTRET, 1'b0);
    wait_rsp(20);
    check_eq("post_rst_lat", 64'(rsp_lat), 64'd4);
    check_eq("post_rst_err", dbg_rsp_err, 1'b0);
    consume();

    // Random traffic; the cycle counter is periodically parked just below a carry.
    for (int i = 0; i < 800; i++) begin
      if ((i % 97) == 0) cyc64[31:0] = 32'hFFFF_FFF0 + 32'($urandom_range(0, 12));
      run_cycle(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_counter_arbiter.md
# csr_counter_arbiter

Shares the single read port of the CPU CSR counter file between the EX-stage CSR instruction path and a debug read port. CPU reads have absolute priority and pass straight through in the same cycle. Debug reads return a coherent 64-bit cycle or instret value. A high/low/high read sequence with bounded retry makes the debug value coherent. The block sits between the EX stage, the debug interface and `csrFile`'s `enable`/`csrOp`/`csrOut` port.

## Interface
- `MAX_RETRY`, default 3: number of re-reads allowed after a torn high word before an error response is returned.
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `cpu_csr_req`  in  1  EX-stage CSR counter read this cycle.
- `cpu_csr_op`  in  2  counter select for the CPU read, using the existing `CSR_*_HIGH/LOW` encodings.
- `cpu_csr_rdata`  out  32  CPU read data: `csr_rdata` when `cpu_csr_req`=1, else 0.
- `dbg_req_valid`  in  1  debug 64-bit read request.
- `dbg_req_ready`  out  1  request accepted when valid && ready.
- `dbg_req_sel`  in  1  counter select: 0 = instret, 1 = cycle; sampled at accept.
- `dbg_rsp_valid`  out  1  response valid.
- `dbg_rsp_ready`  in  1  response consumed when valid && ready.
- `dbg_rsp_data`  out  64  coherent counter value `{hi, lo}`.
- `dbg_rsp_err`  out  1  retry budget exhausted; data is the last read pair.
- `csr_enable`  out  1  drives `csrFile.enable`.
- `csr_op`  out  2  drives `csrFile.csrOp`.
- `csr_rdata`  in  32  from `csrFile.csrOut`; combinational in the same cycle.

## Operation
- States: IDLE, RD_HI1, RD_LO, RD_HI2, RESP.
- IDLE:
  - `dbg_req_ready`=1.
  - On accept: latch `sel`, clear the retry counter, go to RD_HI1.
- CPU priority:
  - When `cpu_csr_req`=1, the port carries `cpu_csr_op`.
  - A debug RD_* state holds in place (stall) and issues nothing that cycle.
- Port drive:
  - `csr_enable` = `cpu_csr_req` | (state ∈ RD_*).
  - `csr_op` = `cpu_csr_op` if `cpu_csr_req`; otherwise HIGH/LOW of the selected counter per state; otherwise 0.
- RD_HI1 (not stalled): `hi1` ← `csr_rdata`; go to RD_LO.
- RD_LO (not stalled): `lo` ← `csr_rdata`; go to RD_HI2.
- RD_HI2 (not stalled), comparing `csr_rdata` with `hi1`:
  - Equal: `dbg_rsp_data` ← `{hi1, lo}`, `err`=0, go to RESP.
  - Unequal and retry < `MAX_RETRY`: retry++, `hi1` ← `csr_rdata`, go to RD_LO. The fresh high word is reused and RD_HI1 is skipped.
  - Unequal and retry == `MAX_RETRY`: `dbg_rsp_data` ← `{csr_rdata, lo}`, `err`=1, go to RESP.
- RESP:
  - `dbg_rsp_valid`=1; data and err are held stable.
  - On `dbg_rsp_ready`, go to IDLE.
- The retry counter is `$clog2(MAX_RETRY+1)` bits wide and never wraps.
- No read side effects: `csrFile` counters are unaffected by reads.

## Timing
- Reset values:
  - state IDLE, `dbg_rsp_valid`=0, `dbg_rsp_data`=0, `dbg_rsp_err`=0, retry=0.
  - `dbg_req_ready`=1 once reset is released.
- CPU path: zero latency, purely combinational; never stalled by debug activity.
- Debug latency:
  - Accept at cycle N gives `dbg_rsp_valid` at N+4 with no contention and no retry.
  - Each CPU-occupied cycle adds 1.
  - Each retry adds 2.
- `dbg_req_ready`=0 in every non-IDLE state.
- The earliest next accept is the cycle after the response handshake.
- Response handshake:
  - `dbg_rsp_valid` may be held arbitrarily long.
  - `dbg_rsp_ready` while `dbg_rsp_valid`=0 is ignored.
- `cpu_csr_req` for the entire debug window: the FSM stalls indefinitely with no timeout.
- `rst_n` low mid-transaction: immediate return to the reset values. The pending request is dropped and no response is issued.

## Structure
- The shared package/header owns:
  - the `CSR_INSTRET_HIGH/LOW` and `CSR_CYCLE_HIGH/LOW` encodings, already shared with `csrFile`;
  - the FSM state enum `dbg_rd_state_e`;
  - the `DBG_SEL_INSTRET`/`DBG_SEL_CYCLE` constants.
- Single module, no sub-modules. The op mux and `csr_enable` are `always_comb`; the FSM and data latches are `always_ff`.

## Test plan
- Idle debug read of cycle, with the model counter at 0x0000_0005_0000_0010 and no CPU traffic:
  - accept at N gives `rsp_valid` at N+4;
  - data = model value sampled at the RD_LO cycle;
  - `err`=0.
- CPU contention: `cpu_csr_req`=1 for 3 cycles starting at N+1.
  - `rsp_valid` at N+7.
  - On each of those cycles, `cpu_csr_rdata` matches the model and `csr_op`=`cpu_csr_op`.
- Carry crossing: the low word is 0xFFFF_FFFF when read in RD_LO.
  - HI2 differs from HI1, giving 1 retry and `rsp` 2 cycles later.
  - data = `{hi+1, low_reread}`, `err`=0.
- Forced tear: a stub that increments the high word on every read, with `MAX_RETRY`=3.
  - `err`=1 after 3 retries.
  - `rsp_valid` at N+10.
- Backpressure: `dbg_rsp_ready`=0 for 5 cycles.
  - data and err are stable throughout; `req_ready` stays 0.
  - IDLE the cycle after ready.
- Reset mid-transaction: `rst_n` low in RD_LO.
  - All outputs return to reset values asynchronously; no response appears.
  - A new request after release completes normally.
